dual_writeback_regfile: RTL and testbench
=========================================

Name: dual_writeback_regfile

Overview:
- Writeback stage and architectural register file for the dual-issue MIPS pipeline.
- Consumes the A/B outputs of the writeback pipeline register.
- Selects each slot's result (memory data or ALU output) and commits up to two register writes per cycle.
- Provides four combinational read ports to decode (rs/rt for slots A and B), with optional same-cycle write-to-read bypass, and exposes the committed results for forwarding and a write-commit counter.

Parameters:
- DATA_WIDTH, 32, width of registers and datapath.
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers; index 0 hardwired to zero).
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored contents only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- RegWriteWInA  in  1  slot A write enable.
- MemtoRegWInA  in  1  slot A result select (1 = ReadDataWInA, 0 = ALUOutWInA).
- ReadDataWInA  in  DATA_WIDTH  slot A memory load data.
- ALUOutWInA  in  DATA_WIDTH  slot A ALU result.
- WriteRegWInA  in  ADDR_WIDTH  slot A destination register.
- RegWriteWInB, MemtoRegWInB, ReadDataWInB, ALUOutWInB, WriteRegWInB  in  1/1/DATA_WIDTH/DATA_WIDTH/ADDR_WIDTH  slot B equivalents.
- RsDA, RtDA, RsDB, RtDB  in  ADDR_WIDTH each  read addresses from decode.
- RdRsDA, RdRtDA, RdRsDB, RdRtDB  out  DATA_WIDTH each  read data.
- ResultWA, ResultWB  out  DATA_WIDTH  selected writeback result per slot (forwarding source).
- CommitCount  out  32  count of committed register writes.

Behaviour:
- Reset (reset=0, async):
  - all registers cleared to 0.
  - CommitCount = 0.
  - Read outputs reflect cleared contents immediately (combinational).
  - A write presented in the same cycle reset is released is not lost: it commits on the first posedge with reset=1.
- Result select, combinational, zero latency:
  - ResultWA = MemtoRegWInA ? ReadDataWInA : ALUOutWInA.
  - ResultWB is the same for slot B.
- Write commit on posedge clk:
  - slot X writes ResultWX to register WriteRegWInX iff RegWriteWInX=1 and WriteRegWInX != 0.
  - Writes to register 0 are discarded.
- Write conflict: A and B both enabled to the same nonzero index → B's value is stored. B is program-order younger.
- Reads, combinational:
  - address 0 always returns 0, regardless of pending writes.
  - BYPASS=1: if a read address equals a nonzero index being written this cycle, return that write's Result. If both slots write it, return ResultWB. Otherwise return stored value.
  - BYPASS=0: always return stored value; the new value is visible the cycle after the posedge.
- CommitCount:
  - increments at posedge by the number of slots with RegWrite=1 and nonzero WriteReg (0, 1 or 2).
  - A same-index conflict still counts 2.
  - Wraps modulo 2^32 with no saturation.
- No stall input: stalling is handled by the upstream pipeline register. When RegWrite is held low, contents and count are unchanged.
- No X propagation: unused data inputs are ignored when RegWrite=0.

Test Plan:
- Reset:
  - Hold reset=0, then release.
  - All four read ports at addresses 0, 1, 31 return 0x00000000.
  - CommitCount=0.
- Dual write:
  - Cycle 1: A writes reg 3 with ALUOut=0x11112222 (MemtoReg=0); B writes reg 7 with ReadData=0xDEADBEEF (MemtoReg=1).
  - Next cycle: RdRsDA(3)=0x11112222, RdRtDB(7)=0xDEADBEEF.
  - CommitCount=2.
- Conflict:
  - A and B both write reg 5, A=0xAAAA0000, B=0xBBBB0000.
  - Reg 5 reads 0xBBBB0000 afterwards.
  - Same cycle with BYPASS=1: RdRsDA(5)=0xBBBB0000.
  - CommitCount advances by 2.
- Register 0:
  - A writes reg 0 with 0xFFFFFFFF.
  - RdRsDA(0)=0 in the same and next cycle.
  - CommitCount unchanged.
- Bypass vs. no bypass:
  - Reg 9 holds 0x1. A writes 0x2 to reg 9; read RsDB=9 in the same cycle.
  - BYPASS=1 returns 0x2; BYPASS=0 returns 0x1 in that cycle and 0x2 in the next.
- Async reset mid-run:
  - After several writes, assert reset between clock edges.
  - All reads and CommitCount drop to 0 before the next posedge.
  - Wrap check: preload CommitCount to 0xFFFFFFFF, commit 2 writes → 0x00000001.

Source files
------------

// File: rtl/dual_writeback_regfile.sv
// Dual-slot writeback stage and architectural register file.
// Two commits per cycle, four read ports with optional write bypass.
module dual_writeback_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWriteWInA,
  input  logic                  MemtoRegWInA,
  input  logic [DATA_WIDTH-1:0] ReadDataWInA,
  input  logic [DATA_WIDTH-1:0] ALUOutWInA,
  input  logic [ADDR_WIDTH-1:0] WriteRegWInA,
  input  logic                  RegWriteWInB,
  input  logic                  MemtoRegWInB,
  input  logic [DATA_WIDTH-1:0] ReadDataWInB,
  input  logic [DATA_WIDTH-1:0] ALUOutWInB,
  input  logic [ADDR_WIDTH-1:0] WriteRegWInB,
  input  logic [ADDR_WIDTH-1:0] RsDA,
  input  logic [ADDR_WIDTH-1:0] RtDA,
  input  logic [ADDR_WIDTH-1:0] RsDB,
  input  logic [ADDR_WIDTH-1:0] RtDB,
  output logic [DATA_WIDTH-1:0] RdRsDA,
  output logic [DATA_WIDTH-1:0] RdRtDA,
  output logic [DATA_WIDTH-1:0] RdRsDB,
  output logic [DATA_WIDTH-1:0] RdRtDB,
  output logic [DATA_WIDTH-1:0] ResultWA,
  output logic [DATA_WIDTH-1:0] ResultWB,
  output logic [31:0]           CommitCount
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [31:0]           commit_q;
  logic                  wen_a;
  logic                  wen_b;
  logic [ADDR_WIDTH-1:0] raddr [4];
  logic [DATA_WIDTH-1:0] rdata [4];

  assign ResultWA = MemtoRegWInA ? ReadDataWInA : ALUOutWInA;
  assign ResultWB = MemtoRegWInB ? ReadDataWInB : ALUOutWInB;

  assign wen_a = RegWriteWInA && (WriteRegWInA != '0);
  assign wen_b = RegWriteWInB && (WriteRegWInB != '0);

  // B is younger, so its write is applied last and wins a conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      commit_q <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wen_a && WriteRegWInA == ADDR_WIDTH'(i))
          regs[i] <= ResultWA;
        if (wen_b && WriteRegWInB == ADDR_WIDTH'(i))
          regs[i] <= ResultWB;
      end
      commit_q <= commit_q + 32'(wen_a) + 32'(wen_b);
    end
  end

  assign CommitCount = commit_q;

  assign raddr[0] = RsDA;
  assign raddr[1] = RtDA;
  assign raddr[2] = RsDB;
  assign raddr[3] = RtDB;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata[p] = regs[raddr[p]];
      if (BYPASS && wen_a && raddr[p] == WriteRegWInA)
        rdata[p] = ResultWA;
      if (BYPASS && wen_b && raddr[p] == WriteRegWInB)
        rdata[p] = ResultWB;
      if (raddr[p] == '0)
        rdata[p] = '0;
    end
  end

  assign RdRsDA = rdata[0];
  assign RdRtDA = rdata[1];
  assign RdRsDB = rdata[2];
  assign RdRtDB = rdata[3];

endmodule

// File: tb/tb_dual_writeback_regfile.sv
// Directed scoreboard bench for dual_writeback_regfile.
// Runs a bypassing and a non-bypassing instance side by side.
module tb_dual_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, mr_a, we_b, mr_b;
  logic [31:0] rd_a, alu_a, rd_b, alu_b;
  logic [4:0]  wr_a, wr_b;
  logic [4:0]  rs_a, rt_a, rs_b, rt_b;

  logic [31:0] p1_rsa, p1_rta, p1_rsb, p1_rtb, p1_ra, p1_rb, p1_cnt;
  logic [31:0] p0_rsa, p0_rta, p0_rsb, p0_rtb, p0_ra, p0_rb, p0_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dual_writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset),
    .RegWriteWInA(we_a), .MemtoRegWInA(mr_a), .ReadDataWInA(rd_a),
    .ALUOutWInA(alu_a), .WriteRegWInA(wr_a),
    .RegWriteWInB(we_b), .MemtoRegWInB(mr_b), .ReadDataWInB(rd_b),
    .ALUOutWInB(alu_b), .WriteRegWInB(wr_b),
    .RsDA(rs_a), .RtDA(rt_a), .RsDB(rs_b), .RtDB(rt_b),
    .RdRsDA(p1_rsa), .RdRtDA(p1_rta), .RdRsDB(p1_rsb), .RdRtDB(p1_rtb),
    .ResultWA(p1_ra), .ResultWB(p1_rb), .CommitCount(p1_cnt)
  );

  dual_writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_nob (
    .clk(clk), .reset(reset),
    .RegWriteWInA(we_a), .MemtoRegWInA(mr_a), .ReadDataWInA(rd_a),
    .ALUOutWInA(alu_a), .WriteRegWInA(wr_a),
    .RegWriteWInB(we_b), .MemtoRegWInB(mr_b), .ReadDataWInB(rd_b),
    .ALUOutWInB(alu_b), .WriteRegWInB(wr_b),
    .RsDA(rs_a), .RtDA(rt_a), .RsDB(rs_b), .RtDB(rt_b),
    .RdRsDA(p0_rsa), .RdRtDA(p0_rta), .RdRsDB(p0_rsb), .RdRtDB(p0_rtb),
    .ResultWA(p0_ra), .ResultWB(p0_rb), .CommitCount(p0_cnt)
  );

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %h required <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    we_a = 0; mr_a = 0; rd_a = 32'h0BAD_0A0A; alu_a = 32'h0BAD_1A1A; wr_a = 5'd0;
    we_b = 0; mr_b = 0; rd_b = 32'h0BAD_0B0B; alu_b = 32'h0BAD_1B1B; wr_b = 5'd0;
  endtask

  task automatic put_a(input logic m, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] r);
    we_a = 1; mr_a = m; rd_a = rd; alu_a = alu; wr_a = r;
  endtask

  task automatic put_b(input logic m, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] r);
    we_b = 1; mr_b = m; rd_b = rd; alu_b = alu; wr_b = r;
  endtask

  task automatic commit_edge();
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
  endtask

  initial begin
    reset = 0;
    idle();
    rs_a = 5'd0; rt_a = 5'd1; rs_b = 5'd31; rt_b = 5'd1;

    // reset held: reads and count zero
    repeat (2) @(negedge clk);
    push("rst_rs0", 0); push("rst_rt1", 0); push("rst_rs31", 0);
    push("rst_cnt", 0); push("rst_cnt_nb", 0);
    #1;
    pop_chk(p1_rsa); pop_chk(p1_rta); pop_chk(p1_rsb);
    pop_chk(p1_cnt); pop_chk(p0_cnt);

    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    push("rel_rs31", 0); push("rel_cnt", 0);
    pop_chk(p0_rsb); pop_chk(p1_cnt);

    // dual write: A ALU -> r3, B memory -> r7
    @(negedge clk);
    put_a(1'b0, 32'h9999_9999, 32'h1111_2222, 5'd3);
    put_b(1'b1, 32'hDEAD_BEEF, 32'h7777_7777, 5'd7);
    push("resA_alu", 32'h1111_2222); push("resB_mem", 32'hDEAD_BEEF);
    #1;
    pop_chk(p1_ra); pop_chk(p1_rb);
    push("dual_r3", 32'h1111_2222); push("dual_r7", 32'hDEAD_BEEF);
    push("dual_cnt", 2); push("dual_r3_nb", 32'h1111_2222);
    rs_a = 5'd3; rt_b = 5'd7;
    commit_edge();
    pop_chk(p1_rsa); pop_chk(p1_rtb); pop_chk(p1_cnt); pop_chk(p0_rsa);

    // same-index conflict: B wins, counts 2
    put_a(1'b0, 0, 32'hAAAA_0000, 5'd5);
    put_b(1'b0, 0, 32'hBBBB_0000, 5'd5);
    rs_a = 5'd5;
    push("cf_byp_same", 32'hBBBB_0000); push("cf_nob_same", 0);
    #1;
    pop_chk(p1_rsa); pop_chk(p0_rsa);
    push("cf_r5", 32'hBBBB_0000); push("cf_r5_nb", 32'hBBBB_0000);
    push("cf_cnt", 4);
    commit_edge();
    pop_chk(p1_rsa); pop_chk(p0_rsa); pop_chk(p1_cnt);

    // writes to r0 discarded, not counted
    put_a(1'b0, 0, 32'hFFFF_FFFF, 5'd0);
    rs_a = 5'd0;
    push("r0_same", 0);
    #1;
    pop_chk(p1_rsa);
    push("r0_next", 0); push("r0_cnt", 4);
    commit_edge();
    pop_chk(p1_rsa); pop_chk(p1_cnt);

    // bypass vs stored: r9 = 1, then write 2
    put_a(1'b0, 0, 32'h1, 5'd9);
    commit_edge();
    put_a(1'b0, 0, 32'h2, 5'd9);
    rs_b = 5'd9;
    push("byp_same", 32'h2); push("nob_same", 32'h1);
    #1;
    pop_chk(p1_rsb); pop_chk(p0_rsb);
    push("byp_next", 32'h2); push("nob_next", 32'h2); push("byp_cnt", 6);
    commit_edge();
    pop_chk(p1_rsb); pop_chk(p0_rsb); pop_chk(p1_cnt);

    // slot-B-only bypass on another port, B priority over A
    put_a(1'b0, 0, 32'h0000_00A1, 5'd12);
    put_b(1'b0, 0, 32'h0000_00B1, 5'd12);
    rt_a = 5'd12;
    push("byp_b_prio", 32'h0000_00B1);
    #1;
    pop_chk(p1_rta);
    commit_edge();

    // async reset between edges
    #2 reset = 0;
    rs_a = 5'd3; rt_a = 5'd12; rs_b = 5'd9; rt_b = 5'd7;
    push("ar_r3", 0); push("ar_r12", 0); push("ar_r9", 0); push("ar_r7", 0);
    push("ar_cnt", 0); push("ar_cnt_nb", 0);
    #1;
    pop_chk(p1_rsa); pop_chk(p1_rta); pop_chk(p1_rsb); pop_chk(p1_rtb);
    pop_chk(p1_cnt); pop_chk(p0_cnt);

    // write presented at reset release commits on first edge
    @(negedge clk);
    reset = 1;
    put_a(1'b1, 32'h0000_0055, 32'h0, 5'd3);
    push("rel_wr_r3", 32'h0000_0055); push("rel_wr_cnt", 1);
    commit_edge();
    pop_chk(p0_rsa); pop_chk(p1_cnt);

    // count wrap from all-ones
    force u_byp.commit_q = 32'hFFFF_FFFF;
    force u_nob.commit_q = 32'hFFFF_FFFF;
    #1;
    release u_byp.commit_q;
    release u_nob.commit_q;
    put_a(1'b0, 0, 32'h10, 5'd10);
    put_b(1'b0, 0, 32'h11, 5'd11);
    push("wrap_cnt", 1); push("wrap_cnt_nb", 1);
    commit_edge();
    pop_chk(p1_cnt); pop_chk(p0_cnt);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_left: observed %0d entries required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
